// File: rtl/ssp_pkg.sv
// Shared constants and occupancy helpers for the SSP transmit and receive FIFOs.
package ssp_pkg;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module ssp_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ssp_txfifo.sv
// SSP transmit FIFO with first-word fall-through head and sticky overrun flag.
// Defining SSP_TXFIFO_LEVEL_EN adds the txlevel occupancy output.
module ssp_txfifo
    import ssp_pkg::*;
#(
    parameter int  WIDTH = WORD_W,
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             pclk,
    input  logic             clear,
    input  logic             psel,
    input  logic             pwrite,
    input  logic [WIDTH-1:0] pwdata,
    input  logic             txfifo_rw,
    output logic [WIDTH-1:0] txdata,
    output logic             txhasword,
    output logic             ssptxintr,
    output logic             txoverrun
`ifdef SSP_TXFIFO_LEVEL_EN
    ,
    output logic [CNT_W-1:0] txlevel
`endif
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    occ_e             occ;
    logic             wr_req, rd_req, do_push, do_pop;
    logic [WIDTH-1:0] head_data;

    assign wr_req = psel & pwrite;
    assign rd_req = ~txfifo_rw;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == CNT_FULL) begin
            occ = OCC_FULL;
        end
    end

    // A write into a full queue is only accepted if the head leaves at the same edge.
    always_comb begin
        do_pop    = rd_req && (occ != OCC_EMPTY);
        do_push   = wr_req && ((occ != OCC_FULL) || do_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q | (wr_req & ~do_push);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    ssp_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (pclk),
        .we_i    (do_push & clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (pwdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    assign txdata    = (occ == OCC_EMPTY) ? '0 : head_data;
    assign txhasword = (occ != OCC_EMPTY);
    assign ssptxintr = (occ == OCC_FULL);
    assign txoverrun = overrun_q;

`ifdef SSP_TXFIFO_LEVEL_EN
    assign txlevel = count_q;
`endif

endmodule
